// File: rtl/fetch_pkg.sv
// Shared MIPS IF-stage definitions: bus widths, bus layouts, FSM encodings, NOP word.
package fetch_pkg;

  localparam int unsigned IF_ID_BUS_W = 64;
  localparam int unsigned JBR_BUS_W   = 33;
  localparam int unsigned EXC_BUS_W   = 33;
  localparam int unsigned STATE_W     = 2;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;

  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } jbr_bus_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } exc_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_bus_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC priority mux: exception redirect, branch redirect, held branch, then PC+4.
module fetch_pc_sel (
  input  logic [31:0] pc,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        jbr_taken,
  input  logic [31:0] jbr_target,
  input  logic        br_pend,
  input  logic [31:0] pend_target,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc + 32'd4;
    if (exc_valid) begin
      next_pc = exc_pc;
    end else if (jbr_taken) begin
      next_pc = jbr_target;
    end else if (br_pend) begin
      next_pc = pend_target;
    end
  end

endmodule

// File: rtl/fetch.sv
// MIPS instruction-fetch stage: PC register, IDLE/WAIT/DONE memory handshake FSM, IF->ID bus.
// FETCH_ADEL_CHECK_EN turns misaligned fetches into a local NOP with fetch_adel raised.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   IF_valid,
  input  logic                   next_fetch,
  input  logic [JBR_BUS_W-1:0]   jbr_bus,
  input  logic [EXC_BUS_W-1:0]   exc_bus,
  output logic                   inst_req,
  output logic [31:0]            inst_addr,
  input  logic                   inst_rvalid,
  input  logic [31:0]            inst_rdata,
  output logic                   IF_over,
  output logic [IF_ID_BUS_W-1:0] IF_ID_bus,
  output logic [31:0]            IF_pc,
  output logic [31:0]            IF_inst,
  output logic                   fetch_adel
);

  jbr_bus_t   jbr;
  exc_bus_t   exc;
  if_id_bus_t if_id;

  logic [STATE_W-1:0] state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        pend_target_q, pend_target_d;
  logic               br_pend_q, br_pend_d;
  logic               cancel_q, cancel_d;
  logic               adel_q, adel_d;
  logic               launch;
  logic [31:0]        next_pc;

  assign jbr = jbr_bus;
  assign exc = exc_bus;

  fetch_pc_sel u_pc_sel (
    .pc          (pc_q),
    .exc_valid   (exc.valid),
    .exc_pc      (exc.pc),
    .jbr_taken   (jbr.taken),
    .jbr_target  (jbr.target),
    .br_pend     (br_pend_q),
    .pend_target (pend_target_q),
    .next_pc     (next_pc)
  );

  // Request is a level decoded from the WAIT state flop.
  assign inst_req   = (state_q == S_WAIT);
  assign inst_addr  = pc_q;
  assign IF_over    = (state_q == S_DONE) && IF_valid;
  assign if_id.pc   = pc_q;
  assign if_id.inst = inst_q;
  assign IF_ID_bus  = if_id;
  assign IF_pc      = pc_q;
  assign IF_inst    = inst_q;
  assign fetch_adel = adel_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inst_q        <= 32'h0;
      pend_target_q <= 32'h0;
      br_pend_q     <= 1'b0;
      cancel_q      <= 1'b0;
      adel_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      pend_target_q <= pend_target_d;
      br_pend_q     <= br_pend_d;
      cancel_q      <= cancel_d;
      adel_q        <= adel_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    pend_target_d = pend_target_q;
    br_pend_d     = br_pend_q;
    cancel_d      = cancel_q;
    adel_d        = adel_q;
    launch        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (exc.valid) pc_d = next_pc;
        if (IF_valid)  launch = 1'b1;
      end
      S_WAIT: begin
        // A redirect never aborts the bus transaction; the stale response is dropped.
        if (exc.valid) begin
          pc_d = next_pc;
          if (inst_rvalid) begin
            cancel_d = 1'b0;
            launch   = 1'b1;
          end else begin
            cancel_d = 1'b1;
          end
        end else if (inst_rvalid) begin
          if (cancel_q) begin
            cancel_d = 1'b0;
            launch   = 1'b1;
          end else begin
            inst_d  = inst_rdata;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (exc.valid) begin
          pc_d   = next_pc;
          adel_d = 1'b0;
          launch = 1'b1;
        end else if (IF_over && next_fetch) begin
          pc_d      = next_pc;
          br_pend_d = 1'b0;
          adel_d    = 1'b0;
          launch    = 1'b1;
        end else if (jbr.taken) begin
          br_pend_d     = 1'b1;
          pend_target_d = jbr.target;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (exc.valid) br_pend_d = 1'b0;

    if (launch) begin
`ifdef FETCH_ADEL_CHECK_EN
      if (pc_d[1:0] != 2'b00) begin
        state_d = S_DONE;
        inst_d  = NOP_INST;
        adel_d  = 1'b1;
      end else begin
        state_d = S_WAIT;
      end
`else
      state_d = S_WAIT;
`endif
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the IF stage against a variable-latency instruction memory model.
module tb_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        IF_valid, next_fetch;
  logic [32:0] jbr_bus, exc_bus;
  logic        inst_req, inst_rvalid, IF_over, fetch_adel;
  logic [31:0] inst_addr, inst_rdata, IF_pc, IF_inst;
  logic [63:0] IF_ID_bus;

  int          tests = 0;
  int          fails = 0;
  int          lat   = 1;
  int          cnt;
  logic [31:0] cap_addr;

  always #5 clk = ~clk;

  fetch dut (
    .clk         (clk),
    .resetn      (resetn),
    .IF_valid    (IF_valid),
    .next_fetch  (next_fetch),
    .jbr_bus     (jbr_bus),
    .exc_bus     (exc_bus),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_rvalid (inst_rvalid),
    .inst_rdata  (inst_rdata),
    .IF_over     (IF_over),
    .IF_ID_bus   (IF_ID_bus),
    .IF_pc       (IF_pc),
    .IF_inst     (IF_inst),
    .fetch_adel  (fetch_adel)
  );

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'h3C00_0000;
  endfunction

  // Memory: responds in the lat-th cycle of a request; address captured on its first cycle.
  assign inst_rvalid = inst_req && (cnt == lat - 1);
  assign inst_rdata  = mw((cnt == 0) ? inst_addr : cap_addr);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= 0;
      cap_addr <= 32'h0;
    end else if (inst_req) begin
      if (cnt == 0) cap_addr <= inst_addr;
      cnt <= inst_rvalid ? 0 : cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ifv, input logic nf, input logic [32:0] jb, input logic [32:0] ex);
    IF_valid   = ifv;
    next_fetch = nf;
    jbr_bus    = jb;
    exc_bus    = ex;
  endtask

  typedef struct {
    logic        ifv;
    logic        nf;
    logic [32:0] jbr;
    logic [32:0] exc;
    logic        req;
    logic [31:0] addr;
    logic        over;
    logic [63:0] bus;
  } vec_t;

  vec_t tv[16];
  int   nrv;

  initial begin
    tv[0]  = '{1'b1, 1'b0, 33'h0, 33'h0, 1'b0, 32'h00, 1'b0, 64'h0};
    tv[1]  = '{1'b1, 1'b0, 33'h0, 33'h0, 1'b1, 32'h00, 1'b0, 64'h0};
    tv[2]  = '{1'b1, 1'b1, 33'h0, 33'h0, 1'b0, 32'h00, 1'b1, {32'h00, mw(32'h00)}};
    tv[3]  = '{1'b1, 1'b0, 33'h0, 33'h0, 1'b1, 32'h04, 1'b0, 64'h0};
    tv[4]  = '{1'b1, 1'b1, 33'h0, 33'h0, 1'b0, 32'h04, 1'b1, {32'h04, mw(32'h04)}};
    tv[5]  = '{1'b1, 1'b0, 33'h0, 33'h0, 1'b1, 32'h08, 1'b0, 64'h0};
    tv[6]  = '{1'b1, 1'b0, {1'b1, 32'h40}, 33'h0, 1'b0, 32'h08, 1'b1, {32'h08, mw(32'h08)}};
    tv[7]  = '{1'b1, 1'b0, 33'h0, 33'h0, 1'b0, 32'h08, 1'b1, {32'h08, mw(32'h08)}};
    tv[8]  = '{1'b1, 1'b1, 33'h0, 33'h0, 1'b0, 32'h08, 1'b1, {32'h08, mw(32'h08)}};
    tv[9]  = '{1'b1, 1'b0, 33'h0, 33'h0, 1'b1, 32'h40, 1'b0, 64'h0};
    tv[10] = '{1'b1, 1'b1, 33'h0, 33'h0, 1'b0, 32'h40, 1'b1, {32'h40, mw(32'h40)}};
    tv[11] = '{1'b1, 1'b0, 33'h0, 33'h0, 1'b1, 32'h44, 1'b0, 64'h0};
    tv[12] = '{1'b1, 1'b1, {1'b1, 32'h80}, {1'b1, 32'h08}, 1'b0, 32'h44, 1'b1, {32'h44, mw(32'h44)}};
    tv[13] = '{1'b1, 1'b0, 33'h0, 33'h0, 1'b1, 32'h08, 1'b0, 64'h0};
    tv[14] = '{1'b0, 1'b1, 33'h0, 33'h0, 1'b0, 32'h08, 1'b0, 64'h0};
    tv[15] = '{1'b1, 1'b0, 33'h0, 33'h0, 1'b0, 32'h08, 1'b1, {32'h08, mw(32'h08)}};

    resetn = 1'b0;
    drive(1'b1, 1'b0, 33'h0, 33'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",  {63'h0, inst_req}, 64'h0);
    chk("rst_over", {63'h0, IF_over}, 64'h0);
    chk("rst_addr", {32'h0, inst_addr}, 64'h0);
    chk("rst_bus",  IF_ID_bus, 64'h0);
    chk("rst_adel", {63'h0, fetch_adel}, 64'h0);

    // Sequential fetch, held branch, IF_valid gating and exc-over-jbr priority at 1-cycle latency.
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      drive(tv[i].ifv, tv[i].nf, tv[i].jbr, tv[i].exc);
      #1;
      chk($sformatf("v%0d_req", i),  {63'h0, inst_req}, {63'h0, tv[i].req});
      chk($sformatf("v%0d_addr", i), {32'h0, inst_addr}, {32'h0, tv[i].addr});
      chk($sformatf("v%0d_over", i), {63'h0, IF_over}, {63'h0, tv[i].over});
      if (tv[i].over) chk($sformatf("v%0d_bus", i), IF_ID_bus, tv[i].bus);
    end
    chk("if_pc",   {32'h0, IF_pc}, 64'h8);
    chk("if_inst", {32'h0, IF_inst}, {32'h0, mw(32'h08)});

    // Jump to a misaligned target.
    @(negedge clk);
    drive(1'b1, 1'b1, {1'b1, 32'h42}, 33'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 33'h0, 33'h0);
    #1;
`ifdef FETCH_ADEL_CHECK_EN
    chk("adel_req",  {63'h0, inst_req}, 64'h0);
    chk("adel_over", {63'h0, IF_over}, 64'h1);
    chk("adel_bus",  IF_ID_bus, {32'h42, 32'h0});
    chk("adel_flag", {63'h0, fetch_adel}, 64'h1);
    drive(1'b1, 1'b1, {1'b1, 32'h100}, 33'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 33'h0, 33'h0);
    #1;
    chk("adel_clr_addr", {32'h0, inst_addr}, 64'h100);
    chk("adel_clr_flag", {63'h0, fetch_adel}, 64'h0);
`else
    chk("mis_req",  {63'h0, inst_req}, 64'h1);
    chk("mis_addr", {32'h0, inst_addr}, 64'h42);
    chk("mis_adel", {63'h0, fetch_adel}, 64'h0);
    @(negedge clk);
    #1;
    chk("mis_bus",  IF_ID_bus, {32'h42, mw(32'h42)});
`endif

    // Reset while a request is outstanding.
    lat = 3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 33'h0, 33'h0);
      #1;
      if (inst_req) break;
    end
    chk("pre_rst_req", {63'h0, inst_req}, 64'h1);
    resetn = 1'b0;
    #1;
    chk("midrst_req",  {63'h0, inst_req}, 64'h0);
    chk("midrst_addr", {32'h0, inst_addr}, 64'h0);
    chk("midrst_over", {63'h0, IF_over}, 64'h0);

    // Exception redirect in IDLE to 0x10, then a 3-cycle memory.
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, 1'b0, 33'h0, {1'b1, 32'h10});
    @(negedge clk);
    drive(1'b1, 1'b0, 33'h0, 33'h0);
    #1;
    chk("l3_idle_req",  {63'h0, inst_req}, 64'h0);
    chk("l3_idle_addr", {32'h0, inst_addr}, 64'h10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("l3_req%0d", k),    {63'h0, inst_req}, 64'h1);
      chk($sformatf("l3_rvalid%0d", k), {63'h0, inst_rvalid}, {63'h0, k == 2});
      chk($sformatf("l3_over%0d", k),   {63'h0, IF_over}, 64'h0);
    end
    @(negedge clk);
    #1;
    chk("l3_over", {63'h0, IF_over}, 64'h1);
    chk("l3_bus",  IF_ID_bus, {32'h10, mw(32'h10)});
    chk("l3_req",  {63'h0, inst_req}, 64'h0);

    // Exception during WAIT at 0x20: the 0x20 response is dropped and 0x8 refetched.
    drive(1'b1, 1'b1, {1'b1, 32'h20}, 33'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 33'h0, {1'b1, 32'h08});
    #1;
    chk("cxl_addr0", {32'h0, inst_addr}, 64'h20);
    @(negedge clk);
    drive(1'b1, 1'b0, 33'h0, 33'h0);
    #1;
    chk("cxl_addr1", {32'h0, inst_addr}, 64'h08);
    chk("cxl_req1",  {63'h0, inst_req}, 64'h1);
    nrv = 0;
    for (int k = 0; k < 12; k++) begin
      if (IF_over) break;
      if (inst_rvalid) nrv++;
      @(negedge clk);
      #1;
    end
    chk("cxl_over", {63'h0, IF_over}, 64'h1);
    chk("cxl_nrv",  64'(nrv), 64'd2);
    chk("cxl_bus",  IF_ID_bus, {32'h08, mw(32'h08)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
